// File: rtl/cellram_async_ctrl.sv
// Asynchronous-mode cellular RAM controller: single words and fixed-length bursts
// with programmable strobe/recovery timing. Optional BCR write after reset: CELLRAM_CRE_INIT_EN.
module cellram_async_ctrl #(
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned T_ACCESS  = 5,
  parameter int unsigned T_RECOVER = 1,
  parameter int unsigned BURST_LEN = 4
`ifdef CELLRAM_CRE_INIT_EN
  ,
  parameter logic [22:0] BCR_VAL   = 23'h009D1F
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] app_data_in,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic              app_wr,
  input  logic              app_rd,
  input  logic              app_burst,
  output logic              data_ok,
  output logic              op_begun,
  output logic              op_finished,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_o,
  input  logic [DATA_W-1:0] mem_dq_i,
  output logic              mem_dq_oe,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_adv_n,
  output logic              mem_lb_n,
  output logic              mem_ub_n,
  output logic              mem_cre,
  output logic              mem_clk
);

  localparam int unsigned       CNT_W    = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [3:0]        TA_LOAD  = 4'(T_ACCESS - 1);
  localparam logic [3:0]        TR_LOAD  = 4'(T_RECOVER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_RECOVER
`ifdef CELLRAM_CRE_INIT_EN
    ,
    S_CFG
`endif
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_timer;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_wr;
  logic               r_cfg;

  logic w_req;
  logic w_ce_n, w_oe_n, w_we_n, w_dq_oe, w_data_ok, w_op_begun, w_op_fin, w_cre;

  assign w_req     = app_wr | app_rd;
  assign mem_adv_n = 1'b0;
  assign mem_clk   = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef CELLRAM_CRE_INIT_EN
      r_state <= S_CFG;
`else
      r_state <= S_IDLE;
`endif
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_req) w_next = S_SETUP;
      S_SETUP:   w_next = S_STROBE;
      S_STROBE:  if (r_timer == '0) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RECOVER;
      S_RECOVER: if (r_timer == '0) w_next = (r_cnt != '0) ? S_SETUP : S_IDLE;
`ifdef CELLRAM_CRE_INIT_EN
      S_CFG:     w_next = S_SETUP;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  // Request latch, word counter, address and phase timer
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer <= '0;
      r_cnt   <= '0;
`ifdef CELLRAM_CRE_INIT_EN
      r_addr  <= ADDR_W'(23'h080000 | BCR_VAL);
      r_wr    <= 1'b1;
      r_cfg   <= 1'b1;
`else
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_cfg   <= 1'b0;
`endif
    end else begin
      if (w_next == S_STROBE && r_state != S_STROBE) begin
        r_timer <= TA_LOAD;
      end else if (w_next == S_RECOVER && r_state != S_RECOVER) begin
        r_timer <= TR_LOAD;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - 4'd1;
      end

      if (r_state == S_IDLE && w_req) begin
        r_addr <= app_addr;
        r_wr   <= app_wr;
        r_cnt  <= app_burst ? CNT_LAST : '0;
      end else if (r_state == S_RECOVER && r_timer == '0) begin
        if (r_cnt != '0) begin
          r_cnt  <= r_cnt - CNT_W'(1);
          r_addr <= r_addr + ADDR_W'(1);
        end else begin
          r_cfg  <= 1'b0;
        end
      end
    end
  end

  // Output decode; every pin is then registered, so pins lag the state by one cycle
  always_comb begin
    w_ce_n     = 1'b1;
    w_oe_n     = 1'b1;
    w_we_n     = 1'b1;
    w_dq_oe    = 1'b0;
    w_data_ok  = 1'b0;
    w_op_begun = 1'b0;
    w_op_fin   = 1'b0;
    w_cre      = 1'b0;
    unique case (r_state)
      S_IDLE: w_op_begun = w_req;
      S_SETUP: begin
        w_ce_n  = 1'b0;
        w_dq_oe = r_wr;
      end
      S_STROBE: begin
        w_ce_n  = 1'b0;
        w_dq_oe = r_wr;
        w_we_n  = ~r_wr;
        w_oe_n  = r_wr;
      end
      S_CAPTURE: begin
        w_ce_n    = 1'b0;
        w_dq_oe   = r_wr;
        w_data_ok = ~r_cfg;
      end
      S_RECOVER: w_op_fin = (r_timer == '0) && (r_cnt == '0) && !r_cfg;
      default: ;
    endcase
`ifdef CELLRAM_CRE_INIT_EN
    w_cre = r_cfg && !w_ce_n;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_ce_n    <= 1'b1;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_lb_n    <= 1'b1;
      mem_ub_n    <= 1'b1;
      mem_dq_oe   <= 1'b0;
      mem_cre     <= 1'b0;
      data_ok     <= 1'b0;
      op_begun    <= 1'b0;
      op_finished <= 1'b0;
      rd_data     <= '0;
      mem_addr    <= '0;
      mem_dq_o    <= '0;
    end else begin
      mem_ce_n    <= w_ce_n;
      mem_oe_n    <= w_oe_n;
      mem_we_n    <= w_we_n;
      mem_lb_n    <= w_ce_n;
      mem_ub_n    <= w_ce_n;
      mem_dq_oe   <= w_dq_oe;
      mem_cre     <= w_cre;
      data_ok     <= w_data_ok;
      op_begun    <= w_op_begun;
      op_finished <= w_op_fin;
      if (r_state == S_SETUP) begin
        mem_addr <= r_addr;
        if (r_wr) mem_dq_o <= r_cfg ? '0 : app_data_in;
      end
      // OE_n is still low on the pin during CAPTURE, so the bus is valid here
      if (r_state == S_CAPTURE && !r_wr && !r_cfg) rd_data <= mem_dq_i;
    end
  end

endmodule

// File: tb/tb_cellram_async_ctrl.sv
// Directed, table-driven bench for cellram_async_ctrl with a combinational RAM read model.
module tb_cellram_async_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] app_data_in;
  logic [22:0] app_addr;
  logic        app_wr, app_rd, app_burst;
  logic        data_ok, op_begun, op_finished;
  logic [15:0] rd_data;
  logic [22:0] mem_addr;
  logic [15:0] mem_dq_o, mem_dq_i;
  logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n;
  logic        mem_lb_n, mem_ub_n, mem_cre, mem_clk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cellram_async_ctrl #(
    .ADDR_W(23), .DATA_W(16), .T_ACCESS(5), .T_RECOVER(1), .BURST_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .app_data_in(app_data_in), .app_addr(app_addr),
    .app_wr(app_wr), .app_rd(app_rd), .app_burst(app_burst),
    .data_ok(data_ok), .op_begun(op_begun), .op_finished(op_finished),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_i(mem_dq_i),
    .mem_dq_oe(mem_dq_oe), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_adv_n(mem_adv_n), .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n), .mem_cre(mem_cre),
    .mem_clk(mem_clk)
  );

  function automatic logic [15:0] model_rd(input logic [22:0] a);
    return (a == 23'h70F0F0) ? 16'h1234 : (a[15:0] ^ 16'hC3C3);
  endfunction

  // Bus reads as DEAD unless OE_n is low, so late capture is visible
  assign mem_dq_i = (!mem_oe_n) ? model_rd(mem_addr) : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr, rd, burst;
    logic [22:0] addr;
    logic [15:0] data;
    int          mid_rd;
    int          exp_dok;
    int          exp_we;
    int          exp_oe;
    int          exp_fin;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    int dok_n = 0, we_cnt = 0, oe_cnt = 0, begun_n = 0, begun_c = -1;
    int fin_c = -1, first_dok = -1;
    logic both_low = 1'b0, rd_oe = 1'b0, adv = 1'b0;
    logic [15:0] wdata = v.data;
    logic [22:0] ea;
    @(posedge clk); #1;
    app_addr = v.addr; app_wr = v.wr; app_rd = v.rd; app_burst = v.burst; app_data_in = v.data;
    for (int c = 0; c < 86; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin app_wr = 1'b0; app_rd = 1'b0; app_burst = 1'b0; end
      if (c == v.mid_rd) app_rd = 1'b1;
      else if (c == v.mid_rd + 1) app_rd = 1'b0;
      if (adv) begin wdata = wdata + 16'd1; app_data_in = wdata; adv = 1'b0; end
      @(negedge clk);
      if (op_begun) begin begun_n++; if (begun_c < 0) begun_c = c; end
      if (!mem_we_n) we_cnt++;
      if (!mem_oe_n) oe_cnt++;
      if (!mem_we_n && !mem_oe_n) both_low = 1'b1;
      if (!v.wr && mem_dq_oe) rd_oe = 1'b1;
      if (data_ok) begin
        if (first_dok < 0) first_dok = c;
        ea = v.addr + 23'(dok_n);
        check("dok_addr", 32'(mem_addr), 32'(ea));
        if (v.wr) begin
          check("wr_data", 32'(mem_dq_o), 32'(wdata));
          check("wr_hold_oe", 32'(mem_dq_oe), 32'd1);
          adv = 1'b1;
        end else begin
          check("rd_data", 32'(rd_data), 32'(model_rd(ea)));
        end
        dok_n++;
      end
      if (op_finished && fin_c < 0) fin_c = c;
      if (fin_c >= 0 && c >= fin_c + 6) break;
    end
    check("op_begun_count", begun_n, 1);
    check("op_begun_cycle", begun_c, 0);
    check("first_data_ok_cycle", first_dok, 7);
    check("data_ok_count", dok_n, v.exp_dok);
    check("we_low_cycles", we_cnt, v.exp_we);
    check("oe_low_cycles", oe_cnt, v.exp_oe);
    check("op_finished_cycle", fin_c, v.exp_fin);
    check("oe_we_both_low", 32'(both_low), 32'd0);
    check("dq_oe_during_read", 32'(rd_oe), 32'd0);
    check("rd_data_held", 32'(rd_data), 32'(v.exp_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, fn, dn, b0, b1;
    vecs[0] = '{wr:1'b1, rd:1'b0, burst:1'b0, addr:23'h555555, data:16'hA5A5, mid_rd:-5,
                exp_dok:1, exp_we:5, exp_oe:0, exp_fin:8, exp_rd:16'h0000};
    vecs[1] = '{wr:1'b0, rd:1'b1, burst:1'b0, addr:23'h70F0F0, data:16'h0000, mid_rd:-5,
                exp_dok:1, exp_we:0, exp_oe:5, exp_fin:8, exp_rd:16'h1234};
    vecs[2] = '{wr:1'b1, rd:1'b1, burst:1'b0, addr:23'h000123, data:16'h0F0F, mid_rd:3,
                exp_dok:1, exp_we:5, exp_oe:0, exp_fin:8, exp_rd:16'h1234};
    vecs[3] = '{wr:1'b0, rd:1'b1, burst:1'b1, addr:23'h7FFFFE, data:16'h0000, mid_rd:-5,
                exp_dok:4, exp_we:0, exp_oe:20, exp_fin:32, exp_rd:16'hC3C2};
    vecs[4] = '{wr:1'b1, rd:1'b0, burst:1'b1, addr:23'h000010, data:16'h1000, mid_rd:-5,
                exp_dok:4, exp_we:20, exp_oe:0, exp_fin:32, exp_rd:16'hC3C2};

    reset = 1'b0; app_data_in = '0; app_addr = '0; app_wr = 1'b0; app_rd = 1'b0; app_burst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl_pins", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}), 32'h1F);
    check("reset_misc_pins", 32'({mem_dq_oe, mem_cre, mem_adv_n, mem_clk}), 32'h0);
    check("reset_pulses", 32'({data_ok, op_begun, op_finished}), 32'h0);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    check("reset_mem_addr", 32'(mem_addr), 32'h0);
    check("reset_mem_dq_o", 32'(mem_dq_o), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    app_rd = 1'b1;
    @(negedge clk);
    check("no_begun_at_release", 32'(op_begun), 32'h0);
    app_rd = 1'b0;
    repeat (20) @(posedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Request held across op_finished restarts on the next IDLE cycle
    bn = 0; fn = 0; b0 = -1; b1 = -1;
    @(posedge clk); #1;
    app_addr = 23'h000040; app_rd = 1'b1;
    for (int c = 0; c < 40 && fn < 2; c++) begin
      @(posedge clk); #1;
      if (bn >= 2) app_rd = 1'b0;
      @(negedge clk);
      if (op_begun) begin
        if (bn == 0) b0 = c; else if (bn == 1) b1 = c;
        bn++;
      end
      if (op_finished) fn++;
    end
    app_rd = 1'b0;
    check("held_first_begun", b0, 0);
    check("held_second_begun", b1, 9);
    check("held_begun_count", bn, 2);
    check("held_finished_count", fn, 2);
    repeat (4) @(posedge clk);

    // Reset during STROBE of a burst write
    @(posedge clk); #1;
    app_addr = 23'h000100; app_wr = 1'b1; app_burst = 1'b1; app_data_in = 16'h7777;
    @(posedge clk); #1;
    app_wr = 1'b0; app_burst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_reset_in_strobe", 32'(mem_we_n), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_strobes_high", 32'({mem_we_n, mem_ce_n, mem_oe_n}), 32'h7);
    check("abort_dq_oe", 32'(mem_dq_oe), 32'h0);
    dn = 0; fn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (data_ok) dn++;
      if (op_finished) fn++;
    end
    check("abort_no_data_ok", dn, 0);
    check("abort_no_finished", fn, 0);
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cellram_async_ctrl.md
Name: cellram_async_ctrl

Overview:
- Memory-side stage directly downstream of dualport_frontend.
- Consumes the arbitrated single-port request (app_addr, app_wr, app_rd, app_burst, app_data_out) and drives the board's 16-bit cellular RAM in asynchronous mode.
- Returns data_ok, op_begun and op_finished to the frontend.
- Single words and fixed-length bursts run as back-to-back asynchronous accesses with programmable access and recovery timing.

Parameters:
- ADDR_W, 23, word address width.
- DATA_W, 16, data width.
- T_ACCESS, 5, clk cycles that the strobe (WE_n or OE_n) is held low per word; legal range 2..15.
- T_RECOVER, 1, idle cycles with CE_n high between words and after each operation; legal range 1..7.
- BURST_LEN, 4, words per burst operation; must be a power of two, 2..16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- app_data_in  in  DATA_W  write data from frontend (app_data_out).
- app_addr  in  ADDR_W  start word address.
- app_wr  in  1  write request, level.
- app_rd  in  1  read request, level.
- app_burst  in  1  burst qualifier; sampled with the request.
- data_ok  out  1  one-cycle pulse per word: write word committed, or rd_data valid.
- op_begun  out  1  one-cycle pulse when a request is accepted.
- op_finished  out  1  one-cycle pulse when an operation completes.
- rd_data  out  DATA_W  read data; held until the next read word.
- mem_addr  out  ADDR_W  RAM address.
- mem_dq_o  out  DATA_W  RAM data out.
- mem_dq_i  in  DATA_W  RAM data in.
- mem_dq_oe  out  1  tristate enable for mem_dq_o.
- mem_ce_n  out  1  chip enable.
- mem_oe_n  out  1  output enable.
- mem_we_n  out  1  write enable.
- mem_adv_n  out  1  address valid; held 0 (async mode).
- mem_lb_n  out  1  lower byte enable.
- mem_ub_n  out  1  upper byte enable.
- mem_cre  out  1  configuration register enable.
- mem_clk  out  1  RAM clock; held 0.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All strobes are registered.
  - mem_ce_n=mem_oe_n=mem_we_n=mem_lb_n=mem_ub_n=1.
  - mem_dq_oe=0, mem_cre=0, mem_adv_n=0, mem_clk=0.
  - data_ok=op_begun=op_finished=0, rd_data=0, mem_addr=0, mem_dq_o=0.
  - State goes to IDLE.
- Reset mid-operation aborts the access. Strobes are high on the first cycle after the reset edge, with no op_finished pulse.
- States: IDLE, SETUP, STROBE, CAPTURE, RECOVER.
- IDLE:
  - If app_wr or app_rd is 1, latch addr, burst flag, and direction; app_wr wins if both are set.
  - Pulse op_begun in the same cycle as the transition to SETUP.
  - Word counter is set to BURST_LEN-1 for a burst, else 0.
- SETUP (1 cycle):
  - Drive mem_addr and mem_ce_n=0, lb_n=ub_n=0.
  - On a write: mem_dq_o=app_data_in and mem_dq_oe=1.
  - Go to STROBE.
- STROBE:
  - Hold mem_we_n=0 (write) or mem_oe_n=0 (read) for exactly T_ACCESS cycles, counted by a 4-bit timer.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - Strobe returns high.
  - On a read, register mem_dq_i into rd_data.
  - Pulse data_ok.
  - Keep mem_dq_oe and the data stable this cycle (write hold).
- RECOVER:
  - mem_ce_n=1 and mem_dq_oe=0 for T_RECOVER cycles.
  - If the word counter is nonzero: decrement it, increment the address, and go to SETUP.
  - Otherwise pulse op_finished on the last RECOVER cycle and return to IDLE.
- Address increment is modulo 2^ADDR_W: 23'h7FFFFF+1 = 23'h000000.
- Burst write data: app_data_in is resampled in each SETUP. The frontend advances its data on the cycle after data_ok.
- Requests are ignored outside IDLE. A request held high across op_finished starts a new operation on the next IDLE cycle.
- Single-word latency, request to data_ok: 1 (IDLE) + 1 + T_ACCESS + 1 cycles. With defaults this is 8 cycles; op_finished follows T_RECOVER cycles later.
- mem_oe_n and mem_we_n are never both 0.

Optional Feature:
- Macro: CELLRAM_CRE_INIT_EN.
- Defined:
  - After reset, enter state CFG before IDLE.
  - CFG performs one write cycle with mem_cre=1, mem_addr=23'h080000|BCR_VAL[22:0].
  - BCR_VAL is an extra parameter, default 23'h009D1F, configuring async mode and drive strength.
  - CFG uses SETUP/STROBE/RECOVER timing, with no op_begun, data_ok or op_finished pulses.
  - Requests are ignored until IDLE is reached.
- Undefined: the CFG state is absent, mem_cre is constant 0, and IDLE is entered directly after reset.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → all outputs at their listed reset values; first op_begun no earlier than 1 cycle after release.
- Single write: app_addr=23'h555555, app_dq=16'hA5A5, app_wr=1 for 1 cycle → op_begun at cycle 0; mem_we_n low for exactly 5 cycles; mem_dq_o=16'hA5A5; data_ok at cycle 7; op_finished at cycle 8.
- Single read: model returns 16'h1234 at 23'h70F0F0, app_rd=1 → mem_oe_n low for 5 cycles; rd_data=16'h1234 with data_ok; mem_dq_oe stays 0 throughout.
- Burst read with wrap: app_addr=23'h7FFFFE, app_burst=1, app_rd=1 → 4 data_ok pulses at addresses 7FFFFE, 7FFFFF, 000000, 000001; exactly one op_finished.
- app_wr and app_rd high simultaneously → write performed; a request pulsed mid-operation (e.g. during STROBE) is not executed.
- Reset asserted during STROBE of a burst write → mem_we_n=1 and mem_ce_n=1 on the next cycle; no data_ok or op_finished; the next request runs normally.
